// File: rtl/ttpu_pkg.sv
// rtl/ttpu_pkg.sv - shared constants, lane types and feeder state encoding
package ttpu_pkg;

  localparam int DIM     = 16;
  localparam int DW      = 16;
  localparam int NW      = 6;
  localparam int TIMEOUT = 40;
  localparam int IW      = $clog2(DIM);
  localparam int TW      = $clog2(TIMEOUT + 1);

  typedef logic [DW-1:0]     word_t;
  typedef word_t [DIM-1:0]   lane_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } feeder_state_e;

  // A job size is usable only when it names at least one and at most DIM lanes.
  function automatic logic n_legal(input logic [NW-1:0] n);
    return (n != '0) && (n <= NW'(DIM));
  endfunction

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// rtl/systolic_operand_feeder_if.sv - operand load stream and result stream bundle
interface systolic_operand_feeder_if;
  import ttpu_pkg::*;

  logic          ld_valid;
  logic          ld_ready;
  logic          ld_sel;
  logic [IW-1:0] ld_addr;
  word_t         ld_data;

  logic          res_valid;
  logic          res_ready;
  logic [IW-1:0] res_idx;
  word_t         res_data;

  modport master (
    input  ld_valid, ld_sel, ld_addr, ld_data, res_ready,
    output ld_ready, res_valid, res_idx, res_data
  );

  modport slave (
    output ld_valid, ld_sel, ld_addr, ld_data, res_ready,
    input  ld_ready, res_valid, res_idx, res_data
  );

endinterface

// File: rtl/feeder_operand_bank.sv
// rtl/feeder_operand_bank.sv - DIM x DW operand register file, one write port, full parallel read
module feeder_operand_bank
  import ttpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  word_t         wdata,
  output lane_vec_t     rdata
);

  lane_vec_t mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem;

endmodule

// File: rtl/systolic_operand_feeder.sv
// rtl/systolic_operand_feeder.sv - buffers A/B operands, runs one systolic array job, streams N results
module systolic_operand_feeder
  import ttpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NW-1:0]              cfg_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  systolic_operand_feeder_if.master  bus,
  output logic                       arr_clear,
  output logic                       arr_en,
  output logic [NW-1:0]              arr_n,
  output lane_vec_t                  arr_a,
  output lane_vec_t                  arr_b,
  input  logic                       arr_ready,
  input  lane_vec_t                  arr_p
);

  feeder_state_e state, state_nx;

  lane_vec_t     a_mem, b_mem;
  lane_vec_t     a_view, b_view, a_launch;
  lane_vec_t     a_q, b_q;
  logic [NW-1:0] n_q;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] idx;

  logic ld_fire, we_a, we_b;
  logic launch, tcnt_clr, tcnt_inc, idx_clr, idx_inc, done_nx, err_nx;

  assign ld_fire = bus.ld_valid & bus.ld_ready;
  assign we_a    = ld_fire & ~bus.ld_sel;
  assign we_b    = ld_fire &  bus.ld_sel;

  feeder_operand_bank u_bank_a (
    .clk   (clk),
    .reset (reset),
    .we    (we_a),
    .waddr (bus.ld_addr),
    .wdata (bus.ld_data),
    .rdata (a_mem)
  );

  feeder_operand_bank u_bank_b (
    .clk   (clk),
    .reset (reset),
    .we    (we_b),
    .waddr (bus.ld_addr),
    .wdata (bus.ld_data),
    .rdata (b_mem)
  );

  // A load landing on the same edge as start must be seen by the job, so the
  // launch snapshot forwards the in-flight write over the bank contents.
  always_comb begin
    a_view = a_mem;
    b_view = b_mem;
    if (we_a) a_view[bus.ld_addr] = bus.ld_data;
    if (we_b) b_view[bus.ld_addr] = bus.ld_data;
    for (int i = 0; i < DIM; i++) begin
      a_launch[i] = (NW'(i) < cfg_n) ? a_view[i] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    tcnt_clr = 1'b0;
    tcnt_inc = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (n_legal(cfg_n)) begin
            launch   = 1'b1;
            state_nx = CLEAR;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      CLEAR: begin
        tcnt_clr = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        if (arr_ready) begin
          idx_clr  = 1'b1;
          state_nx = DRAIN;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.res_ready) begin
          if (NW'(idx) == n_q - NW'(1)) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      tcnt <= '0;
      idx  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= done_nx;
      err  <= err_nx;
      if (launch) begin
        n_q <= cfg_n;
        a_q <= a_launch;
        b_q <= b_view;
      end
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + TW'(1);
      if (idx_clr)       idx <= '0;
      else if (idx_inc)  idx <= idx + IW'(1);
    end
  end

  assign busy      = (state != IDLE);
  assign arr_clear = (state == CLEAR);
  assign arr_en    = (state == RUN);
  assign arr_n     = n_q;
  assign arr_a     = a_q;
  assign arr_b     = b_q;

  // arr_en is low in DRAIN, so arr_p is frozen and a stalled beat stays put.
  assign bus.ld_ready  = (state == IDLE);
  assign bus.res_valid = (state == DRAIN);
  assign bus.res_idx   = (state == DRAIN) ? idx : '0;
  assign bus.res_data  = (state == DRAIN) ? arr_p[idx] : '0;

endmodule
